picorv32_freeahb_bridge: RTL and testbench

Second-generation bridge between the PicoRV32 native memory interface and the FreeAHB master. It sits between the core and the FreeAHB master inside the riscv/picorv wrapper. Unlike the first adapter, it:
- coalesces write strobes into the fewest aligned byte, halfword or word transfers;
- supports a configurable byte-lane order;
- registers read data;
- has an optional bus-timeout watchdog.

---
 rtl/picorv_ahb_pkg.sv | 19 +
 rtl/picorv_wstrb_splitter.sv | 57 +++++
 rtl/picorv32_freeahb_bridge.sv | 195 +++++++++++++++++++
 tb/tb_picorv32_freeahb_bridge.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/picorv_ahb_pkg.sv
// Shared types and constants for the PicoRV32 to FreeAHB bridge.
package picorv_ahb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      WR_REQ,
      WR_DRAIN,
      RESP
   } state_t;

   localparam logic [2:0]  SIZE_BYTE = 3'd0;
   localparam logic [2:0]  SIZE_HALF = 3'd1;
   localparam logic [2:0]  SIZE_WORD = 3'd2;

   localparam logic [31:0] ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/picorv_wstrb_splitter.sv
// Picks the next aligned byte/halfword/word piece from a remaining strobe mask
// and places its bytes on the AHB lanes that match the piece address.
module picorv_wstrb_splitter
   import picorv_ahb_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic [3:0]  mask,
   input  logic [31:0] wdata,
   output logic [2:0]  size,
   output logic [1:0]  offset,
   output logic [31:0] lane_data,
   output logic [3:0]  mask_next
);

   logic [1:0]  lane;
   logic [1:0]  last;
   logic [3:0]  sel;
   logic [3:0]  sel_src;
   logic [31:0] data_src;

   always_comb begin
      lane = 2'd0;
      casez (mask)
         4'b???1: lane = 2'd0;
         4'b??10: lane = 2'd1;
         4'b?100: lane = 2'd2;
         4'b1000: lane = 2'd3;
         default: lane = 2'd0;
      endcase
   end

   always_comb begin
      size = SIZE_BYTE;
      last = 2'd0;
      sel  = 4'b0001 << lane;
      if (mask == 4'b1111) begin
         size = SIZE_WORD;
         last = 2'd3;
         sel  = 4'b1111;
      end else if (!lane[0] && mask[{lane[1], 1'b1}]) begin
         size = SIZE_HALF;
         last = 2'd1;
         sel  = 4'b0011 << lane;
      end
   end

   // Big-endian lane i lives at offset 3-i, so the piece starts at its highest lane.
   assign offset    = BIG_ENDIAN ? 2'(2'd3 - lane - last) : lane;
   assign mask_next = mask & ~sel;

   assign sel_src  = BIG_ENDIAN ? {sel[0], sel[1], sel[2], sel[3]} : sel;
   assign data_src = BIG_ENDIAN ? {wdata[7:0], wdata[15:8], wdata[23:16], wdata[31:24]} : wdata;

   assign lane_data = data_src & {{8{sel_src[3]}}, {8{sel_src[2]}}, {8{sel_src[1]}}, {8{sel_src[0]}}};

endmodule

// File: rtl/picorv32_freeahb_bridge.sv
// PicoRV32 native memory interface to FreeAHB master bridge with write-strobe
// coalescing and registered read data. Optional watchdog: PICORV_AHB_TIMEOUT_EN.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for mem_valid; request fields captured on entry out
// RD_REQ   | word read request presented, waiting for freeahb_next
// RD_WAIT  | read accepted, waiting for freeahb_ready
// WR_REQ   | write pieces presented back to back until the mask is empty
// WR_DRAIN | last write accepted, waiting for its data phase to finish
// RESP     | one-cycle mem_ready pulse
module picorv32_freeahb_bridge
   import picorv_ahb_pkg::*;
#(
   parameter bit          BIG_ENDIAN     = 1'b0,
   parameter logic [31:0] RD_MIN_LEN     = 32'd32,
   parameter logic [3:0]  INSTR_PROT     = 4'b0000,
   parameter logic [3:0]  DATA_PROT      = 4'b0001,
   parameter int          TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic        mem_instr,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_wstrb,
   output logic        mem_ready,
   output logic [31:0] mem_rdata,
   output logic        freeahb_valid,
   output logic        freeahb_write,
   output logic        freeahb_read,
   output logic [31:0] freeahb_addr,
   output logic [31:0] freeahb_wdata,
   output logic [2:0]  freeahb_size,
   output logic [31:0] freeahb_min_len,
   output logic        freeahb_cont,
   output logic        freeahb_lock,
   output logic [3:0]  freeahb_prot,
   input  logic        freeahb_next,
   input  logic        freeahb_ready,
   input  logic [31:0] freeahb_rdata,
   output logic        bus_err
);

   state_t      state, state_next;
   logic [29:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  mask_q;
   logic        instr_q;
   logic        timeout;

   logic [2:0]  pc_size;
   logic [1:0]  pc_offset;
   logic [31:0] pc_data;
   logic [3:0]  pc_mask_next;

   logic        unused_addr_lsb;
   assign unused_addr_lsb = ^mem_addr[1:0];

   assign freeahb_cont = 1'b0;
   assign freeahb_lock = 1'b0;

   picorv_wstrb_splitter #(
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_splitter (
      .mask      (mask_q),
      .wdata     (wdata_q),
      .size      (pc_size),
      .offset    (pc_offset),
      .lane_data (pc_data),
      .mask_next (pc_mask_next)
   );

`ifdef PICORV_AHB_TIMEOUT_EN
   localparam int              CW      = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [CW-1:0]   TC_LOAD = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] tmo_cnt;

   // Reloads on every state change, so each waiting state gets its own budget.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         tmo_cnt <= TC_LOAD;
      else if (state_next != state)
         tmo_cnt <= TC_LOAD;
      else if (tmo_cnt != '0)
         tmo_cnt <= tmo_cnt - CW'(1);
   end

   assign timeout = (state inside {RD_REQ, RD_WAIT, WR_REQ, WR_DRAIN}) && (tmo_cnt == '0);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         bus_err <= 1'b0;
      else if (timeout)
         bus_err <= 1'b1;
   end
`else
   assign timeout = 1'b0;
   assign bus_err = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         mask_q  <= '0;
         instr_q <= 1'b0;
      end else begin
         state <= state_next;
         if (state == IDLE && mem_valid) begin
            addr_q  <= mem_addr[31:2];
            wdata_q <= mem_wdata;
            mask_q  <= mem_wstrb;
            instr_q <= mem_instr;
         end else if (state == WR_REQ && freeahb_next) begin
            mask_q <= pc_mask_next;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         mem_rdata <= '0;
      else if (timeout)
         mem_rdata <= ERR_RDATA;
      else if (state == RD_WAIT && freeahb_ready)
         mem_rdata <= freeahb_rdata;
   end

   always_comb begin
      state_next      = state;
      mem_ready       = 1'b0;
      freeahb_valid   = 1'b0;
      freeahb_write   = 1'b0;
      freeahb_read    = 1'b0;
      freeahb_addr    = '0;
      freeahb_wdata   = '0;
      freeahb_size    = SIZE_BYTE;
      freeahb_min_len = '0;
      freeahb_prot    = '0;

      if (state != IDLE)
         freeahb_prot = instr_q ? INSTR_PROT : DATA_PROT;

      case (state)
         IDLE: begin
            if (mem_valid)
               state_next = (mem_wstrb == 4'b0000) ? RD_REQ : WR_REQ;
         end
         RD_REQ: begin
            freeahb_valid   = 1'b1;
            freeahb_read    = 1'b1;
            freeahb_size    = SIZE_WORD;
            freeahb_addr    = {addr_q, 2'b00};
            freeahb_min_len = RD_MIN_LEN;
            if (freeahb_next)
               state_next = RD_WAIT;
         end
         RD_WAIT: begin
            if (freeahb_ready)
               state_next = RESP;
         end
         WR_REQ: begin
            freeahb_valid   = 1'b1;
            freeahb_write   = 1'b1;
            freeahb_size    = pc_size;
            freeahb_addr    = {addr_q, pc_offset};
            freeahb_wdata   = pc_data;
            freeahb_min_len = 32'd8 << pc_size;
            if (freeahb_next && pc_mask_next == 4'b0000)
               state_next = WR_DRAIN;
         end
         WR_DRAIN: begin
            if (freeahb_next)
               state_next = RESP;
         end
         RESP: begin
            mem_ready  = 1'b1;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase

      if (timeout) begin
         freeahb_valid = 1'b0;
         freeahb_read  = 1'b0;
         freeahb_write = 1'b0;
         state_next    = RESP;
      end
   end

endmodule

// File: tb/tb_picorv32_freeahb_bridge.sv
// Directed bench for picorv32_freeahb_bridge: little- and big-endian instances
// share stimulus; expected pieces and latencies are hand-computed.
module tb_picorv32_freeahb_bridge;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        mem_valid = 1'b0;
   logic        mem_instr = 1'b0;
   logic [31:0] mem_addr = '0;
   logic [31:0] mem_wdata = '0;
   logic [3:0]  mem_wstrb = '0;
   logic        next = 1'b0;
   logic        ready = 1'b0;
   logic [31:0] rdata = '0;

   logic        le_ready, le_valid, le_write, le_read, le_cont, le_lock, le_err;
   logic [31:0] le_rdata, le_addr, le_wdata, le_min_len;
   logic [2:0]  le_size;
   logic [3:0]  le_prot;
   logic        be_ready, be_valid, be_write, be_read, be_cont, be_lock, be_err;
   logic [31:0] be_rdata, be_addr, be_wdata, be_min_len;
   logic [2:0]  be_size;
   logic [3:0]  be_prot;

   logic [141:0] le_all, be_all;
   assign le_all = {le_valid, le_write, le_read, le_addr, le_wdata, le_size, le_min_len,
                    le_cont, le_lock, le_prot, le_ready, le_rdata, le_err};
   assign be_all = {be_valid, be_write, be_read, be_addr, be_wdata, be_size, be_min_len,
                    be_cont, be_lock, be_prot, be_ready, be_rdata, be_err};

   int checks = 0;
   int errors = 0;

   logic [98:0] le_q[$];
   logic [98:0] be_q[$];

   always #5 clk = ~clk;

   picorv32_freeahb_bridge #(.BIG_ENDIAN(1'b0), .TIMEOUT_CYCLES(4)) dut_le (
      .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(le_ready), .mem_rdata(le_rdata), .freeahb_valid(le_valid),
      .freeahb_write(le_write), .freeahb_read(le_read), .freeahb_addr(le_addr),
      .freeahb_wdata(le_wdata), .freeahb_size(le_size), .freeahb_min_len(le_min_len),
      .freeahb_cont(le_cont), .freeahb_lock(le_lock), .freeahb_prot(le_prot),
      .freeahb_next(next), .freeahb_ready(ready), .freeahb_rdata(rdata), .bus_err(le_err));

   picorv32_freeahb_bridge #(.BIG_ENDIAN(1'b1), .TIMEOUT_CYCLES(4)) dut_be (
      .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .mem_instr(mem_instr),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
      .mem_ready(be_ready), .mem_rdata(be_rdata), .freeahb_valid(be_valid),
      .freeahb_write(be_write), .freeahb_read(be_read), .freeahb_addr(be_addr),
      .freeahb_wdata(be_wdata), .freeahb_size(be_size), .freeahb_min_len(be_min_len),
      .freeahb_cont(be_cont), .freeahb_lock(be_lock), .freeahb_prot(be_prot),
      .freeahb_next(next), .freeahb_ready(ready), .freeahb_rdata(rdata), .bus_err(be_err));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [98:0] pc(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
      return {a, d, s, 32'd8 << s};
   endfunction

   // Cycle 1 is the cycle mem_valid is raised; cyc is the cycle mem_ready is seen, -1 if never.
   task automatic run_read(input logic [31:0] a, input logic i, input logic [31:0] d,
                           output int cyc, output int nreq, output logic [31:0] raddr,
                           output logic [3:0] rprot, output logic [31:0] rlen);
      bit done = 1'b0;
      mem_addr = a; mem_instr = i; mem_wstrb = 4'b0000; mem_valid = 1'b1;
      next = 1'b1; ready = 1'b1; rdata = d;
      cyc = 1; nreq = 0; raddr = '0; rprot = '1; rlen = '0;
      while (!done && cyc < 20) begin
         tick;
         cyc++;
         if (le_valid && le_read) begin
            nreq++; raddr = le_addr; rprot = le_prot; rlen = le_min_len;
         end
         if (le_ready) done = 1'b1;
      end
      mem_valid = 1'b0; mem_instr = 1'b0; ready = 1'b0;
      if (!done) cyc = -1;
   endtask

   task automatic run_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output int cyc);
      bit done = 1'b0;
      le_q.delete(); be_q.delete();
      mem_addr = a; mem_wdata = d; mem_wstrb = s; mem_instr = 1'b0; mem_valid = 1'b1; next = 1'b1;
      cyc = 1;
      while (!done && cyc < 20) begin
         tick;
         cyc++;
         if (le_valid && le_write) le_q.push_back({le_addr, le_wdata, le_size, le_min_len});
         if (be_valid && be_write) be_q.push_back({be_addr, be_wdata, be_size, be_min_len});
         if (le_ready) done = 1'b1;
      end
      mem_valid = 1'b0; mem_wstrb = 4'b0000;
      if (!done) cyc = -1;
   endtask

   task automatic test_reset;
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (le_all !== '0) begin errors++; $display("FAIL reset_le: got %h expected 0", le_all); end
      checks++;
      if (be_all !== '0) begin errors++; $display("FAIL reset_be: got %h expected 0", be_all); end
      resetn = 1'b1;
      tick;
   endtask

   task automatic test_read;
      logic [31:0] va[2], vd[2], raddr, rlen;
      logic        vi[2];
      logic [3:0]  rprot;
      int          cyc, nreq;
      va[0] = 32'h0000_0100; vi[0] = 1'b0; vd[0] = 32'h1234_5678;
      va[1] = 32'h0000_0102; vi[1] = 1'b1; vd[1] = 32'h8765_4321;
      for (int v = 0; v < 2; v++) begin
         run_read(va[v], vi[v], vd[v], cyc, nreq, raddr, rprot, rlen);
         checks++;
         if (cyc !== 4) begin errors++; $display("FAIL read%0d_latency: got %0d expected 4", v, cyc); end
         checks++;
         if (nreq !== 1) begin errors++; $display("FAIL read%0d_nreq: got %0d expected 1", v, nreq); end
         checks++;
         if (raddr !== 32'h0000_0100) begin errors++; $display("FAIL read%0d_addr: got %h expected 00000100", v, raddr); end
         checks++;
         if (rprot !== (vi[v] ? 4'b0000 : 4'b0001)) begin errors++; $display("FAIL read%0d_prot: got %h", v, rprot); end
         checks++;
         if (rlen !== 32'd32) begin errors++; $display("FAIL read%0d_min_len: got %0d expected 32", v, rlen); end
         checks++;
         if (le_rdata !== vd[v] || be_rdata !== vd[v]) begin
            errors++; $display("FAIL read%0d_rdata: got %h/%h expected %h", v, le_rdata, be_rdata, vd[v]);
         end
         tick;
         checks++;
         if (le_ready !== 1'b0) begin errors++; $display("FAIL read%0d_ready_pulse: got %b expected 0", v, le_ready); end
      end
   endtask

   task automatic test_write_split;
      logic [31:0] va[6];
      logic [3:0]  vs[6];
      int          vn[6];
      logic [98:0] el[6][2];
      logic [98:0] eb[6][2];
      int          cyc;
      va[0] = 32'h201; vs[0] = 4'b1111; vn[0] = 1;
      el[0][0] = pc(32'h200, 32'hAABBCCDD, 3'd2); eb[0][0] = pc(32'h200, 32'hDDCCBBAA, 3'd2);
      va[1] = 32'h303; vs[1] = 4'b0111; vn[1] = 2;
      el[1][0] = pc(32'h300, 32'h0000CCDD, 3'd1); eb[1][0] = pc(32'h302, 32'hDDCC0000, 3'd1);
      el[1][1] = pc(32'h302, 32'h00BB0000, 3'd0); eb[1][1] = pc(32'h301, 32'h0000BB00, 3'd0);
      va[2] = 32'h400; vs[2] = 4'b0101; vn[2] = 2;
      el[2][0] = pc(32'h400, 32'h000000DD, 3'd0); eb[2][0] = pc(32'h403, 32'hDD000000, 3'd0);
      el[2][1] = pc(32'h402, 32'h00BB0000, 3'd0); eb[2][1] = pc(32'h401, 32'h0000BB00, 3'd0);
      va[3] = 32'h500; vs[3] = 4'b1100; vn[3] = 1;
      el[3][0] = pc(32'h502, 32'hAABB0000, 3'd1); eb[3][0] = pc(32'h500, 32'h0000BBAA, 3'd1);
      va[4] = 32'h600; vs[4] = 4'b1010; vn[4] = 2;
      el[4][0] = pc(32'h601, 32'h0000CC00, 3'd0); eb[4][0] = pc(32'h602, 32'h00CC0000, 3'd0);
      el[4][1] = pc(32'h603, 32'hAA000000, 3'd0); eb[4][1] = pc(32'h600, 32'h000000AA, 3'd0);
      va[5] = 32'h700; vs[5] = 4'b0110; vn[5] = 2;
      el[5][0] = pc(32'h701, 32'h0000CC00, 3'd0); eb[5][0] = pc(32'h702, 32'h00CC0000, 3'd0);
      el[5][1] = pc(32'h702, 32'h00BB0000, 3'd0); eb[5][1] = pc(32'h701, 32'h0000BB00, 3'd0);

      for (int v = 0; v < 6; v++) begin
         run_write(va[v], 32'hAABBCCDD, vs[v], cyc);
         checks++;
         if (cyc !== vn[v] + 3) begin errors++; $display("FAIL write%0d_latency: got %0d expected %0d", v, cyc, vn[v] + 3); end
         checks++;
         if (le_q.size() !== vn[v] || be_q.size() !== vn[v]) begin
            errors++; $display("FAIL write%0d_pieces: got %0d/%0d expected %0d", v, le_q.size(), be_q.size(), vn[v]);
         end else begin
            for (int p = 0; p < vn[v]; p++) begin
               checks++;
               if (le_q[p] !== el[v][p]) begin errors++; $display("FAIL write%0d_le_piece%0d: got %h expected %h", v, p, le_q[p], el[v][p]); end
               checks++;
               if (be_q[p] !== eb[v][p]) begin errors++; $display("FAIL write%0d_be_piece%0d: got %h expected %h", v, p, be_q[p], eb[v][p]); end
            end
         end
         tick;
      end
      checks++;
      if (le_rdata !== 32'h8765_4321) begin errors++; $display("FAIL rdata_hold: got %h expected 87654321", le_rdata); end
   endtask

   task automatic test_stall;
      int cyc = 0;
      bit done = 1'b0;
      mem_addr = 32'h800; mem_wdata = 32'h11223344; mem_wstrb = 4'b1111; mem_valid = 1'b1; next = 1'b0;
      tick;
`ifdef PICORV_AHB_TIMEOUT_EN
      while (!done && cyc < 12) begin
         if (le_ready) done = 1'b1;
         else begin tick; cyc++; end
      end
      mem_valid = 1'b0;
      checks++;
      if (!done || cyc !== 4) begin errors++; $display("FAIL timeout_latency: got %0d done %b expected 4", cyc, done); end
      checks++;
      if (le_err !== 1'b1) begin errors++; $display("FAIL timeout_bus_err: got %b expected 1", le_err); end
      checks++;
      if (le_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL timeout_rdata: got %h expected deadbeef", le_rdata); end
      checks++;
      if (le_valid !== 1'b0) begin errors++; $display("FAIL timeout_valid: got %b expected 0", le_valid); end
`else
      for (int k = 0; k < 5; k++) begin
         checks++;
         if ({le_valid, le_addr, le_ready} !== {1'b1, 32'h800, 1'b0}) begin
            errors++; $display("FAIL stall%0d: got valid %b addr %h ready %b expected 1 00000800 0", k, le_valid, le_addr, le_ready);
         end
         tick;
      end
      checks++;
      if (le_err !== 1'b0) begin errors++; $display("FAIL stall_bus_err: got %b expected 0", le_err); end
      next = 1'b1;
      while (!done && cyc < 10) begin
         tick; cyc++;
         if (le_ready) done = 1'b1;
      end
      mem_valid = 1'b0;
      checks++;
      if (!done || cyc !== 2) begin errors++; $display("FAIL stall_release: got %0d done %b expected 2", cyc, done); end
`endif
      tick;
   endtask

   task automatic test_reset_mid;
      logic [31:0] raddr, rlen;
      logic [3:0]  rprot;
      int          cyc, nreq;
      mem_addr = 32'h900; mem_wstrb = 4'b0000; mem_valid = 1'b1; next = 1'b1; ready = 1'b0; rdata = 32'h5555_5555;
      tick;
      tick;
      mem_valid = 1'b0;
      #2 resetn = 1'b0;
      #1;
      checks++;
      if (le_all !== '0) begin errors++; $display("FAIL reset_mid_le: got %h expected 0", le_all); end
      checks++;
      if (be_all !== '0) begin errors++; $display("FAIL reset_mid_be: got %h expected 0", be_all); end
      tick;
      resetn = 1'b1;
      tick;
      run_read(32'h104, 1'b0, 32'hCAFE_F00D, cyc, nreq, raddr, rprot, rlen);
      checks++;
      if (cyc !== 4) begin errors++; $display("FAIL post_reset_latency: got %0d expected 4", cyc); end
      checks++;
      if (le_rdata !== 32'hCAFE_F00D || raddr !== 32'h104) begin
         errors++; $display("FAIL post_reset_read: got %h at %h expected cafef00d at 00000104", le_rdata, raddr);
      end
      tick;
   endtask

   initial begin
      test_reset;
      test_read;
      test_write_split;
      test_stall;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got %0d checks %0d errors", checks, errors);
      $fatal(1);
   end

endmodule
